// File: rtl/uart_tx_frame.sv
// uart_tx_frame -- parametrised UART transmitter, one frame per accepted request.
//
// Frame: start(0), DATA_BITS data bits LSB first, optional parity, STOP_BITS stop(1).
// Every bit is held for CLKS_PER_BIT clocks. o_tx is registered and is driven
// with the value of the upcoming bit on each bit boundary, so the start bit
// appears on the cycle right after accept.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> a parity bit follows the data; PARITY_ODD picks odd (1) or even (0)
//   undefined -> no parity state or logic, PARITY_ODD is ignored
//
// Ports:
//   i_clk       clock
//   i_rst       synchronous active-high reset, aborts a frame in flight
//   i_tx_dv     request valid; accepted when o_tx_ready is high
//   i_tx_data   payload, sampled only on accept
//   o_tx_ready  high only while idle
//   o_tx        serial line, idles high
//   o_tx_active high from the first start-bit cycle to the last stop-bit cycle
//   o_tx_done   one-cycle pulse on the first idle cycle after a frame
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_tx_dv,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx_ready,
    output logic                 o_tx,
    output logic                 o_tx_active,
    output logic                 o_tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    // Elaboration-time legality checks on the configuration.
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
        $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
    end

    logic [2:0]           state;
    logic [CW-1:0]        baud;
    logic [BW-1:0]        bit_idx;   // data bit index, reused to count stop bits
    logic [DATA_BITS-1:0] sh;        // sh[0] is the data bit currently on the line
`ifdef UART_TX_PARITY_EN
    logic                 par_q;     // parity captured at accept; sh is consumed by shifting
`endif

    logic bit_end;
    assign bit_end    = (baud == BAUD_LAST);
    assign o_tx_ready = (state == S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            baud        <= '0;
            bit_idx     <= '0;
            sh          <= '0;
            o_tx        <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            o_tx_done <= 1'b0;
            if (state == S_IDLE) begin
                // Counters are held at zero while idle.
                baud    <= '0;
                bit_idx <= '0;
                if (i_tx_dv) begin
                    sh          <= i_tx_data;
`ifdef UART_TX_PARITY_EN
                    par_q       <= (^i_tx_data) ^ (PARITY_ODD != 0);
`endif
                    o_tx        <= 1'b0;
                    o_tx_active <= 1'b1;
                    state       <= S_START;
                end
            end else begin
                baud <= bit_end ? '0 : baud + CW'(1);
                if (bit_end) begin
                    case (state)
                        S_START: begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                            o_tx    <= sh[0];
                        end
                        S_DATA: begin
                            if (bit_idx == DATA_LAST) begin
                                bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                                state   <= S_PARITY;
                                o_tx    <= par_q;
`else
                                state   <= S_STOP;
                                o_tx    <= 1'b1;
`endif
                            end else begin
                                bit_idx <= bit_idx + BW'(1);
                                o_tx    <= sh[1];
                                sh      <= {1'b0, sh[DATA_BITS-1:1]};
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        S_PARITY: begin
                            state   <= S_STOP;
                            bit_idx <= '0;
                            o_tx    <= 1'b1;
                        end
`endif
                        S_STOP: begin
                            if (bit_idx == STOP_LAST) begin
                                state       <= S_IDLE;
                                bit_idx     <= '0;
                                o_tx        <= 1'b1;
                                o_tx_active <= 1'b0;
                                o_tx_done   <= 1'b1;
                            end else begin
                                bit_idx <= bit_idx + BW'(1);
                            end
                        end
                        default: begin
                            state       <= S_IDLE;
                            o_tx        <= 1'b1;
                            o_tx_active <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame. Three instances share clock and reset:
//   u0: 8 data bits, 1 stop, even parity sense
//   u1: 7 data bits, 2 stop
//   u2: 8 data bits, 1 stop, odd parity sense
// Expected frames are hand-written bit strings, bit k = k-th bit on the line.
module tb_uart_tx_frame;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv   [3];
    logic [8:0] data [3];
    logic       tx   [3];
    logic       act  [3];
    logic       done [3];
    logic       rdy  [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
        .i_clk(clk), .i_rst(rst), .i_tx_dv(dv[0]), .i_tx_data(data[0][7:0]),
        .o_tx_ready(rdy[0]), .o_tx(tx[0]), .o_tx_active(act[0]), .o_tx_done(done[0]));

    uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) u1 (
        .i_clk(clk), .i_rst(rst), .i_tx_dv(dv[1]), .i_tx_data(data[1][6:0]),
        .o_tx_ready(rdy[1]), .o_tx(tx[1]), .o_tx_active(act[1]), .o_tx_done(done[1]));

    uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u2 (
        .i_clk(clk), .i_rst(rst), .i_tx_dv(dv[2]), .i_tx_data(data[2][7:0]),
        .o_tx_ready(rdy[2]), .o_tx(tx[2]), .o_tx_active(act[2]), .o_tx_done(done[2]));

    // Accept one frame on instance s and check every cycle of it plus the done cycle.
    task automatic run_frame(input int s, input logic [8:0] d, input logic [15:0] exp,
                             input int nb, input string nm);
        int ndone, nact;
        ndone = 0;
        nact  = 0;
        @(posedge clk); #1;
        dv[s] = 1'b1; data[s] = d;
        @(posedge clk); #1;               // accept edge T
        dv[s] = 1'b0; data[s] = ~d;       // later data changes must not leak in
        for (int j = 1; j <= nb * C; j++) begin
            @(negedge clk);
            total++;
            if (tx[s] !== exp[(j - 1) / C]) begin
                bad++;
                $display("FAIL %s bit cyc=%0d tx=%b want=%b", nm, j, tx[s], exp[(j - 1) / C]);
            end
            if (act[s] === 1'b1) nact++;
            if (done[s] === 1'b1) ndone++;
        end
        total++;
        if (nact != nb * C) begin
            bad++;
            $display("FAIL %s active_cycles got=%0d want=%0d", nm, nact, nb * C);
        end
        total++;
        if (ndone != 0) begin
            bad++;
            $display("FAIL %s early_done got=%0d want=0", nm, ndone);
        end
        @(negedge clk);                   // cycle T+N*C+1
        total++;
        if ({done[s], rdy[s], tx[s], act[s]} !== 4'b1110) begin
            bad++;
            $display("FAIL %s end_cycle done,rdy,tx,act=%b want=1110", nm,
                     {done[s], rdy[s], tx[s], act[s]});
        end
        @(negedge clk);
        total++;
        if ({done[s], tx[s], act[s]} !== 3'b010) begin
            bad++;
            $display("FAIL %s after_end done,tx,act=%b want=010", nm, {done[s], tx[s], act[s]});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                total++;
                if ({tx[s], rdy[s], act[s], done[s]} !== 4'b1100) begin
                    bad++;
                    $display("FAIL reset_idle u%0d cyc=%0d tx,rdy,act,done=%b want=1100", s, j,
                             {tx[s], rdy[s], act[s], done[s]});
                end
            end
        end
    endtask

    task automatic test_frame_8();
        logic [15:0] e;
        e = (P != 0) ? 16'b101_0100_1010 : 16'b11_0100_1010;
        run_frame(0, 9'h0A5, e, 10 + P, "frame8_a5");
    endtask

    task automatic test_parity_odd();
        logic [15:0] e;
        e = (P != 0) ? 16'b111_0100_1010 : 16'b11_0100_1010;
        run_frame(2, 9'h0A5, e, 10 + P, "frame8_a5_odd");
    endtask

    task automatic test_width_stop();
        logic [15:0] e;
        e = (P != 0) ? 16'b110_1000_0010 : 16'b11_1000_0010;
        run_frame(1, 9'h041, e, 10 + P, "frame7_41_2stop");
    endtask

    task automatic test_back_to_back();
        logic [15:0] e0, e1;
        int nb, ndone, t2;
        nb = 10 + P;
        e0 = (P != 0) ? 16'b100_0000_0000 : 16'b10_0000_0000;
        e1 = (P != 0) ? 16'b101_1111_1110 : 16'b11_1111_1110;
        ndone = 0;
        @(posedge clk); #1;
        dv[0] = 1'b1; data[0] = 9'h000;
        @(posedge clk); #1;               // accept edge T, request stays high
        data[0] = 9'h0FF;
        for (int j = 1; j <= nb * C; j++) begin
            @(negedge clk);
            total++;
            if (tx[0] !== e0[(j - 1) / C]) begin
                bad++;
                $display("FAIL b2b_first cyc=%0d tx=%b want=%b", j, tx[0], e0[(j - 1) / C]);
            end
            if (done[0] === 1'b1) ndone++;
        end
        @(negedge clk);                   // single idle-high cycle, second accept here
        total++;
        if ({tx[0], done[0], rdy[0], act[0]} !== 4'b1110) begin
            bad++;
            $display("FAIL b2b_gap tx,done,rdy,act=%b want=1110", {tx[0], done[0], rdy[0], act[0]});
        end
        t2 = nb * C + 2;
        for (int j = t2; j < t2 + nb * C; j++) begin
            @(negedge clk);
            dv[0] = 1'b0;
            total++;
            if ({tx[0], act[0], rdy[0]} !== {e1[(j - t2) / C], 2'b10}) begin
                bad++;
                $display("FAIL b2b_second cyc=%0d tx,act,rdy=%b want=%b", j,
                         {tx[0], act[0], rdy[0]}, {e1[(j - t2) / C], 2'b10});
            end
            if (done[0] === 1'b1) ndone++;
        end
        @(negedge clk);
        total++;
        if (done[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done2 done=%b want=1", done[0]);
        end
        total++;
        if (ndone != 0) begin
            bad++;
            $display("FAIL b2b_done_count got=%0d want=0", ndone);
        end
        for (int j = 0; j < 2 * C; j++) begin
            @(negedge clk);
            total++;
            if ({tx[0], act[0]} !== 2'b10) begin
                bad++;
                $display("FAIL b2b_no_third cyc=%0d tx,act=%b want=10", j, {tx[0], act[0]});
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] e;
        @(posedge clk); #1;
        dv[0] = 1'b1; data[0] = 9'h0A5;
        @(posedge clk); #1;
        dv[0] = 1'b0;
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({tx[0], rdy[0], act[0], done[0]} !== 4'b1100) begin
            bad++;
            $display("FAIL midrst_abort tx,rdy,act,done=%b want=1100",
                     {tx[0], rdy[0], act[0], done[0]});
        end
        rst = 1'b0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            total++;
            if ({tx[0], done[0], act[0]} !== 3'b100) begin
                bad++;
                $display("FAIL midrst_quiet cyc=%0d tx,done,act=%b want=100", j,
                         {tx[0], done[0], act[0]});
            end
        end
        e = (P != 0) ? 16'b101_0100_1010 : 16'b11_0100_1010;
        run_frame(0, 9'h0A5, e, 10 + P, "midrst_resend");
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            dv[s]   = 1'b0;
            data[s] = 9'h000;
        end
        test_reset();
        test_frame_8();
        test_parity_odd();
        test_width_stop();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that serialises one frame per accepted request. It supports configurable data width, one or two stop bits and optional compiled-in parity. Requests use a ready/valid handshake, and the block reports busy and done status. It sits between a byte-producing source (FIFO or controller) and the serial TX pin. It is the configurable replacement for the fixed 8N1 sender.

## Interface
- CLKS_PER_BIT, 87: clock cycles per serial bit (f_clk / baud); legal range ≥ 2.
- DATA_BITS, 8: data bits per frame; legal 5–9.
- STOP_BITS, 1: stop bits per frame; legal 1 or 2.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; only used when UART_TX_PARITY_EN is defined.

Ports:
- i_clk  in  1  clock; one clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_tx_dv  in  1  request valid.
- i_tx_data  in  DATA_BITS  frame payload; sampled only on accept.
- o_tx_ready  out  1  high only in IDLE; accept = i_tx_dv & o_tx_ready.
- o_tx  out  1  serial line; idle high; registered.
- o_tx_active  out  1  high from the first start-bit cycle to the last stop-bit cycle.
- o_tx_done  out  1  one-cycle pulse at frame completion.

## Operation
- FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE.
- IDLE:
  - o_tx = 1, o_tx_ready = 1.
  - On accept: latch i_tx_data into the shift register, clear the bit and baud counters, go to START.
- START: o_tx = 0 for CLKS_PER_BIT cycles.
- DATA:
  - Send DATA_BITS bits, LSB first, each held for CLKS_PER_BIT cycles.
  - Bit index counter width: $clog2(DATA_BITS) bits, or 1 if larger.
- PARITY (macro defined only):
  - Even parity bit = XOR-reduce(latched data).
  - Odd parity bit = XNOR-reduce(latched data).
  - Held for CLKS_PER_BIT cycles.
- STOP: o_tx = 1 for STOP_BITS × CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, wraps to 0 on every bit boundary.
  - Never free-runs in IDLE.
- Input changes and requests during a frame:
  - i_tx_data changes after accept have no effect on the frame in flight.
  - i_tx_dv while busy is ignored and not queued; the source must hold it until ready.
- Reset:
  - Values: o_tx = 1, o_tx_ready = 1, o_tx_active = 0, o_tx_done = 0, FSM = IDLE, counters = 0.
  - Reset mid-frame aborts the frame on that edge with no o_tx_done pulse.
  - A request asserted together with i_rst is not accepted.

## Timing
- Frame length N = 1 + DATA_BITS + P + STOP_BITS bits, where P = 1 with the macro defined, else 0.
- Accept at clock edge T.
- Start bit: o_tx = 0 on cycles T+1 .. T+CLKS_PER_BIT.
- Bit k (k = 0 for start) occupies cycles T+1+k·CLKS_PER_BIT .. T+(k+1)·CLKS_PER_BIT.
- o_tx_active = 1 on exactly cycles T+1 .. T+N·CLKS_PER_BIT.
- Cycle T+N·CLKS_PER_BIT+1:
  - FSM is in IDLE.
  - o_tx_done = 1 for this single cycle.
  - o_tx_ready = 1.
  - A request here is accepted, and its start bit begins on the next cycle.
- Back-to-back frame period: N·CLKS_PER_BIT + 1 cycles, with exactly one idle-high cycle between frames.
- Latency from accept to the falling edge of o_tx: 1 cycle.

## Configuration
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state is present, and PARITY_ODD selects the parity sense.
- Undefined:
  - No PARITY state and no parity logic.
  - PARITY_ODD is ignored.
  - Frame is DATA_BITS-N-STOP_BITS.

## Test plan
- Reset and idle: CLKS_PER_BIT=4, defaults, i_rst held 3 cycles, i_tx_dv=0 → o_tx=1, o_tx_ready=1, o_tx_active=0, o_tx_done=0 for 50 cycles.
- 8N1 frame: macro off, i_tx_data=8'hA5, single accept → o_tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 cycles total); o_tx_done pulses exactly once at T+41.
- Parity: macro on, 8'hA5 (four ones) → parity bit 0 with PARITY_ODD=0, 1 with PARITY_ODD=1; frame = 44 cycles.
- Width and stop bits: DATA_BITS=7, STOP_BITS=2, macro off, data 7'h41 → bits 0,1,0,0,0,0,0,1,1,1; o_tx_active high for exactly 40 cycles.
- Back-to-back: i_tx_dv held high with data 8'h00 then 8'hFF → second start bit begins at T+42; exactly one idle cycle between frames; intermediate requests ignored.
- Reset mid-frame: i_rst pulsed at cycle T+17 → o_tx=1, o_tx_ready=1 next cycle; no o_tx_done; a new frame sent afterwards is bit-exact.
